// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Steps a 4-input combinational block through ABCD = 0..15 in ascending
//   order. Each vector is held for DWELL cycles and Y is captured on the
//   edge that ends the last cycle of that vector. The sweep builds a 16-bit
//   truth table, a ones count and the lowest vector that produced Y=1.
//
// Parameters
//   DWELL    cycles each vector is held before Y is captured (1..255)
//
// Ports
//   clk_i    clock, all state changes on the rising edge
//   rst_i    synchronous active-high reset, overrides everything
//   start_i  begin a sweep, taken only in IDLE and only without abort_i
//   abort_i  cancel a running sweep; results clear and no done pulse follows
//   y_i      Y output of the block under test
//   a_o..d_o vector to the block, a_o = idx[3] ... d_o = idx[0]
//   busy_o   high while a sweep is running
//   done_o   one-cycle pulse when a sweep completes
//   table_o  bit i = captured Y for ABCD = i
//   ones_o   number of set bits in table_o (0..16)
//   first_o  lowest i with table_o[i] = 1, 0 when found_o = 0
//   found_o  at least one table_o bit set
module truth_table_sweeper #(
  parameter int DWELL = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        y_i,
  output logic        a_o,
  output logic        b_o,
  output logic        c_o,
  output logic        d_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] table_o,
  output logic [4:0]  ones_o,
  output logic [3:0]  first_o,
  output logic        found_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Dwell count value on which Y is captured for the current vector.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  dwell_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] table_q;
  logic [4:0]  ones_q;
  logic [3:0]  first_q;
  logic        found_q;

  // Next value of the per-vector results when Y is captured this cycle.
  logic [15:0] table_d;
  logic [4:0]  ones_d;
  logic [3:0]  first_d;
  logic        found_d;

  always_comb begin
    table_d        = table_q;
    table_d[idx_q] = y_i;
    ones_d         = ones_q + {4'd0, y_i};
    first_d        = first_q;
    found_d        = found_q;
    // Only the first hit records its index; later hits leave it alone.
    if (y_i && !found_q) begin
      first_d = idx_q;
      found_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      dwell_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 16'd0;
      ones_q  <= 5'd0;
      first_q <= 4'd0;
      found_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (abort_i) begin
            // Abort wins over a same-cycle start and clears held results.
            table_q <= 16'd0;
            ones_q  <= 5'd0;
            first_q <= 4'd0;
            found_q <= 1'b0;
          end else if (start_i) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            idx_q   <= 4'd0;
            dwell_q <= 8'd0;
            table_q <= 16'd0;
            ones_q  <= 5'd0;
            first_q <= 4'd0;
            found_q <= 1'b0;
          end
        end

        S_RUN: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= 4'd0;
            dwell_q <= 8'd0;
            table_q <= 16'd0;
            ones_q  <= 5'd0;
            first_q <= 4'd0;
            found_q <= 1'b0;
          end else if (dwell_q == DWELL_LAST) begin
            table_q <= table_d;
            ones_q  <= ones_d;
            first_q <= first_d;
            found_q <= found_d;
            dwell_q <= 8'd0;
            if (idx_q == 4'd15) begin
              // idx returns to 0 so the vector outputs read 0000 in FIN.
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= 4'd0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            dwell_q <= dwell_q + 8'd1;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= 4'd0;
          dwell_q <= 8'd0;
        end
      endcase
    end
  end

  // idx is held at 0 outside RUN, so a plain decode gives 0000 there.
  assign a_o     = idx_q[3];
  assign b_o     = idx_q[2];
  assign c_o     = idx_q[1];
  assign d_o     = idx_q[0];
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign table_o = table_q;
  assign ones_o  = ones_q;
  assign first_o = first_q;
  assign found_o = found_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Which instance the scenario drives: 0 -> DWELL=4, 1 -> DWELL=1.
  logic sel = 1'b0;
  logic rst_g = 1'b0, rst_ev = 1'b0, start_r = 1'b0, abort_r = 1'b0;
  logic [15:0] tt4 = 16'd0, tt1 = 16'd0;

  logic rst4, start4, abort4, y4, a4, b4, c4, d4, busy4, done4, found4;
  logic rst1, start1, abort1, y1, a1, b1, c1, d1, busy1, done1, found1;
  logic [15:0] tab4, tab1;
  logic [4:0]  ones4, ones1;
  logic [3:0]  first4, first1;

  assign rst4   = rst_g | (rst_ev & ~sel);
  assign rst1   = rst_g | (rst_ev & sel);
  assign start4 = start_r & ~sel;
  assign start1 = start_r & sel;
  assign abort4 = abort_r & ~sel;
  assign abort1 = abort_r & sel;

  // The block under test: Y is a lookup of the chosen function's truth table.
  assign y4 = tt4[{a4, b4, c4, d4}];
  assign y1 = tt1[{a1, b1, c1, d1}];

  truth_table_sweeper #(.DWELL(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .start_i(start4), .abort_i(abort4), .y_i(y4),
    .a_o(a4), .b_o(b4), .c_o(c4), .d_o(d4), .busy_o(busy4), .done_o(done4),
    .table_o(tab4), .ones_o(ones4), .first_o(first4), .found_o(found4));

  truth_table_sweeper #(.DWELL(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .start_i(start1), .abort_i(abort1), .y_i(y1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
    .table_o(tab1), .ones_o(ones1), .first_o(first1), .found_o(found1));

  // Observed outputs of the selected instance.
  logic        o_busy, o_done, o_found;
  logic [3:0]  o_abcd, o_first;
  logic [15:0] o_tab;
  logic [4:0]  o_ones;
  assign o_busy  = sel ? busy1 : busy4;
  assign o_done  = sel ? done1 : done4;
  assign o_found = sel ? found1 : found4;
  assign o_abcd  = sel ? {a1, b1, c1, d1} : {a4, b4, c4, d4};
  assign o_first = sel ? first1 : first4;
  assign o_tab   = sel ? tab1 : tab4;
  assign o_ones  = sel ? ones1 : ones4;

  // Functions of the block under test, expressed on ABCD.
  function automatic logic yfun(input int mode, input logic [15:0] rnd, input int i);
    logic a, b, c, d;
    a = i[3]; b = i[2]; c = i[1]; d = i[0];
    case (mode)
      0:       yfun = ~a & ~d & b & c;
      1:       yfun = 1'b1;
      2:       yfun = 1'b0;
      default: yfun = rnd[i];
    endcase
  endfunction

  // Reference results for a completed sweep over truth table t.
  logic [15:0] e_tab;
  logic [4:0]  e_ones;
  logic [3:0]  e_first;
  logic        e_found;

  task automatic set_func(input int mode);
    logic [15:0] rnd, t;
    rnd = 16'($urandom);
    for (int i = 0; i < 16; i++) t[i] = yfun(mode, rnd, i);
    if (sel) tt1 = t; else tt4 = t;
    e_tab = t; e_ones = 5'd0; e_first = 4'd0; e_found = 1'b0;
    for (int i = 0; i < 16; i++) if (t[i]) e_ones++;
    for (int i = 15; i >= 0; i--) if (t[i]) begin e_first = 4'(i); e_found = 1'b1; end
  endtask

  // Runs one sweep on the selected instance. Entered at a negedge with the
  // DUT idle; returns at the negedge of its first idle cycle after FIN.
  // ev: 0 none, 1 abort, 2 start re-pulse, 3 reset, injected in the first
  // cycle that vector ev_idx is driven.
  task automatic run_sweep(input string nm, input int ev, input int ev_idx);
    int dw, kmax, kev, busy_cnt, done_cnt, done_k, bad_abcd, bad_res, bad_stop;
    bit stopped;
    logic [3:0] idx_e;
    dw = sel ? 1 : 4;
    kmax = 16 * dw + 2;
    kev = ev_idx * dw + 1;
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    bad_abcd = 0; bad_res = 0; bad_stop = 0; stopped = 0;
    start_r = 1'b1;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      start_r = 1'b0; abort_r = 1'b0; rst_ev = 1'b0;
      if (ev != 0 && k == kev + 1 && ev != 2) stopped = 1;
      if (o_busy) busy_cnt++;
      if (o_done) begin done_cnt++; done_k = k; end
      if (stopped) begin
        if (o_busy || o_done || o_abcd !== 4'd0 || o_tab !== 16'd0 || o_ones !== 5'd0 ||
            o_first !== 4'd0 || o_found !== 1'b0) bad_stop++;
      end else begin
        idx_e = (k <= 16 * dw) ? 4'((k - 1) / dw) : 4'd0;
        if (o_abcd !== idx_e) bad_abcd++;
        if (k >= 16 * dw + 1 && (o_tab !== e_tab || o_ones !== e_ones ||
            o_first !== e_first || o_found !== e_found)) bad_res++;
      end
      if (!stopped && ev != 0 && k == kev) begin
        if (ev == 1) abort_r = 1'b1;
        else if (ev == 2) start_r = 1'b1;
        else rst_ev = 1'b1;
      end
    end
    tests++;
    if (busy_cnt != (stopped ? kev : 16 * dw)) begin
      fails++; $display("FAIL %s busy_cycles got %0d want %0d", nm, busy_cnt, stopped ? kev : 16 * dw);
    end
    tests++;
    if (done_cnt != (stopped ? 0 : 1) || (!stopped && done_k != 16 * dw + 1)) begin
      fails++; $display("FAIL %s done_pulse got count %0d at cycle %0d want %0d at %0d",
                        nm, done_cnt, done_k, stopped ? 0 : 1, 16 * dw + 1);
    end
    tests++;
    if (bad_abcd != 0) begin
      fails++; $display("FAIL %s abcd_sequence got %0d bad cycles want 0", nm, bad_abcd);
    end
    if (stopped) begin
      tests++;
      if (bad_stop != 0) begin
        fails++; $display("FAIL %s stop_state got %0d nonzero cycles want 0", nm, bad_stop);
      end
    end else begin
      tests++;
      if (bad_res != 0) begin
        fails++; $display("FAIL %s results_done_hold got %0d bad cycles want 0", nm, bad_res);
      end
      tests++;
      if (o_tab !== e_tab || o_ones !== e_ones || o_first !== e_first || o_found !== e_found) begin
        fails++; $display("FAIL %s results got tab=%h ones=%0d first=%0d found=%0d want tab=%h ones=%0d first=%0d found=%0d",
                          nm, o_tab, o_ones, o_first, o_found, e_tab, e_ones, e_first, e_found);
      end
    end
  endtask

  task automatic test_reset();
    rst_g = 1'b1; start_r = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy4, done4, a4, b4, c4, d4, tab4, ones4, first4, found4} !== 31'd0) begin
      fails++; $display("FAIL reset_dut4 got %h want 0", {busy4, done4, a4, b4, c4, d4, tab4, ones4, first4, found4});
    end
    tests++;
    if ({busy1, done1, a1, b1, c1, d1, tab1, ones1, first1, found1} !== 31'd0) begin
      fails++; $display("FAIL reset_dut1 got %h want 0", {busy1, done1, a1, b1, c1, d1, tab1, ones1, first1, found1});
    end
    rst_g = 1'b0; start_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dwell4_func();
    sel = 1'b0; set_func(0);
    run_sweep("dw4_func", 0, 0);
    tests++;
    if (tab4 !== 16'h0040 || ones4 !== 5'd1 || first4 !== 4'd6 || found4 !== 1'b1) begin
      fails++; $display("FAIL dw4_func_const got tab=%h ones=%0d first=%0d found=%0d want 0040 1 6 1",
                        tab4, ones4, first4, found4);
    end
  endtask

  task automatic test_dwell1_ones();
    sel = 1'b1; set_func(1);
    run_sweep("dw1_ones", 0, 0);
    tests++;
    if (tab1 !== 16'hFFFF || ones1 !== 5'd16 || first1 !== 4'd0 || found1 !== 1'b1) begin
      fails++; $display("FAIL dw1_ones_const got tab=%h ones=%0d first=%0d found=%0d want FFFF 16 0 1",
                        tab1, ones1, first1, found1);
    end
  endtask

  task automatic test_y_zero();
    sel = 1'b0; set_func(2);
    run_sweep("dw4_zero", 0, 0);
    sel = 1'b1; set_func(2);
    run_sweep("dw1_zero", 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      sel = n[0]; set_func(3);
      run_sweep(sel ? "dw1_rand" : "dw4_rand", 0, 0);
    end
  endtask

  task automatic test_abort();
    sel = 1'b0; set_func(3);
    run_sweep("dw4_abort5", 1, 5);
    sel = 1'b1; set_func(1);
    run_sweep("dw1_abort5", 1, 5);
  endtask

  task automatic test_restart();
    sel = 1'b0; set_func(0);
    run_sweep("dw4_restart9", 2, 9);
  endtask

  task automatic test_rst_mid();
    sel = 1'b0; set_func(1);
    run_sweep("dw4_rst12", 3, 12);
    set_func(0);
    run_sweep("dw4_after_rst", 0, 0);
  endtask

  task automatic test_start_abort_idle();
    sel = 1'b0;
    start_r = 1'b1; abort_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0; abort_r = 1'b0;
    tests++;
    if (busy4 !== 1'b0 || {a4, b4, c4, d4} !== 4'd0 || tab4 !== 16'd0) begin
      fails++; $display("FAIL start_abort_idle got busy=%b abcd=%b tab=%h want 0 0000 0000",
                        busy4, {a4, b4, c4, d4}, tab4);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL start_abort_idle_later got busy=%b done=%b want 0 0", busy4, done4);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1; set_func(3);
    run_sweep("dw1_b2b_a", 0, 0);
    set_func(3);
    run_sweep("dw1_b2b_b", 0, 0);
    sel = 1'b0; set_func(3);
    run_sweep("dw4_b2b_a", 0, 0);
    set_func(0);
    run_sweep("dw4_b2b_b", 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dwell4_func();
    test_dwell1_ones();
    test_y_zero();
    test_random();
    test_abort();
    test_restart();
    test_rst_mid();
    test_start_abort_idle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
